// File: rtl/lfo_step_sched.sv
// Step scheduler for the triangle-wave LFO: paces nxt pulses at act_per clocks,
// drives wav_rst on retrigger, and swaps in new periods only on step boundaries.
// Ports: clk, rst (sync, active-high), en, retrig, cfg_valid/cfg_period/cfg_ready
// (period offer), nxt (step pulse), wav_rst, step_cnt, busy. All outputs registered.
module lfo_step_sched #(
  parameter int P_W     = 16,
  parameter int CNT_W   = 16,
  parameter int RST_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             retrig,
  input  logic             cfg_valid,
  input  logic [P_W-1:0]   cfg_period,
  output logic             cfg_ready,
  output logic             nxt,
  output logic             wav_rst,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy
);

  localparam int RL_W = ($clog2(RST_LEN) > 0) ? $clog2(RST_LEN) : 1;
  localparam logic [RL_W-1:0] RL_LD = RL_W'(RST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RETRIG = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [P_W-1:0]   act_q, act_d;
  logic [P_W-1:0]   pend_q, pend_d;
  logic             pvld_q, pvld_d;
  logic [P_W-1:0]   cnt_q, cnt_d;
  logic [RL_W-1:0]  rcnt_q, rcnt_d;
  logic             nxt_q, nxt_d;
  logic             wrst_q, wrst_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             busy_q;
  logic             rdy_q;

  logic             hs;
  logic [P_W-1:0]   cfg_c;
  logic [P_W-1:0]   per_nx;
  logic [P_W-1:0]   ld;

  // Periods below 2 would let nxt stay high back-to-back.
  assign cfg_c  = (cfg_period < P_W'(2)) ? P_W'(2) : cfg_period;
  assign hs     = cfg_valid & rdy_q;
  assign per_nx = pvld_q ? pend_q : act_q;
  // Period to install at a boundary: a same-cycle offer beats the pending one.
  assign ld     = hs ? cfg_c : per_nx;

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    nxt_d   = 1'b0;
    wrst_d  = 1'b0;
    scnt_d  = scnt_q;
    if (hs) begin
      pend_d = cfg_c;
      pvld_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        act_d  = ld;
        pvld_d = 1'b0;
        if (en) begin
          if (retrig) begin
            state_d = RETRIG;
            wrst_d  = 1'b1;
            rcnt_d  = RL_LD;
            scnt_d  = '0;
          end else begin
            state_d = RUN;
            cnt_d   = ld - P_W'(1);
          end
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          act_d   = ld;
          pvld_d  = 1'b0;
        end else if (retrig) begin
          state_d = RETRIG;
          wrst_d  = 1'b1;
          rcnt_d  = RL_LD;
          scnt_d  = '0;
          act_d   = ld;
          pvld_d  = 1'b0;
        end else if (cnt_q == '0) begin
          nxt_d  = 1'b1;
          scnt_d = scnt_q + CNT_W'(1);
          cnt_d  = per_nx - P_W'(1);
          act_d  = per_nx;
          pvld_d = hs;
        end else begin
          cnt_d = cnt_q - P_W'(1);
        end
      end
      RETRIG: begin
        if (retrig) begin
          wrst_d = 1'b1;
          rcnt_d = RL_LD;
          scnt_d = '0;
          act_d  = ld;
          pvld_d = 1'b0;
        end else if (rcnt_q == '0) begin
          state_d = en ? RUN : IDLE;
          act_d   = ld;
          pvld_d  = 1'b0;
          cnt_d   = ld - P_W'(1);
        end else begin
          wrst_d = 1'b1;
          rcnt_d = rcnt_q - RL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= P_W'(2);
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      nxt_q   <= 1'b0;
      wrst_q  <= 1'b0;
      scnt_q  <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      nxt_q   <= nxt_d;
      wrst_q  <= wrst_d;
      scnt_q  <= scnt_d;
      busy_q  <= (state_d != IDLE);
      rdy_q   <= ~pvld_d;
    end
  end

  assign cfg_ready = rdy_q;
  assign nxt       = nxt_q;
  assign wav_rst   = wrst_q;
  assign step_cnt  = scnt_q;
  assign busy      = busy_q;

endmodule
